// File: rtl/gf_mul_exp_seq_if.sv
// gf_mul_exp_seq_if: request/response bundle for the sequential GF(2^m) unit
interface gf_mul_exp_seq_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH:0]   polyn_red_in;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] out;

    modport master (
        output start, op, polyn_red_in, a, b,
        input  busy, done, out
    );

    modport slave (
        input  start, op, polyn_red_in, a, b,
        output busy, done, out
    );
endinterface

// File: rtl/gf_mul_exp_seq.sv
// gf_mul_exp_seq: bit-serial GF(2^m) add/mult/exp unit; GF_INV_EN enables op=11 Fermat inverse
module gf_mul_exp_seq #(
    parameter int DATA_WIDTH = 32
) (
    input logic            clk,
    input logic            rst_n,
    gf_mul_exp_seq_if.slave bus
);
    localparam int M  = DATA_WIDTH;
    localparam int CW = $clog2(M);

    typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

    state_t         state;
    logic           is_exp;
    logic [M-1:0]   a_r, b_r, poly_r, acc, prod, out_r;
    logic [CW-1:0]  cnt, ebit;
    logic           busy_r, done_r;
    logic [M-1:0]   mcand, mbits, shifted, prod_next;

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.out  = out_r;

    // One interleaved shift-reduce-accumulate step of the current pass
    always_comb begin
        mcand     = (state == SQR) ? acc : a_r;
        mbits     = (state == MUL && !is_exp) ? b_r : acc;
        shifted   = {prod[M-2:0], 1'b0} ^ (prod[M-1] ? poly_r : '0);
        prod_next = shifted ^ (mbits[cnt] ? mcand : '0);
    end

    // Control FSM with registered handshake outputs and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            is_exp <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            poly_r <= '0;
            acc    <= '0;
            prod   <= '0;
            out_r  <= '0;
            cnt    <= '0;
            ebit   <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_r    <= bus.a;
                        b_r    <= bus.b;
                        poly_r <= bus.polyn_red_in[M-1:0];
                        acc    <= M'(1);
                        prod   <= '0;
                        cnt    <= CW'(M-1);
                        ebit   <= CW'(M-1);
                        case (bus.op)
                            2'b00: begin
                                out_r  <= bus.a ^ bus.b;
                                done_r <= 1'b1;
                                state  <= DONE;
                            end
                            2'b01: begin
                                is_exp <= 1'b0;
                                busy_r <= 1'b1;
                                state  <= MUL;
                            end
                            2'b10: begin
                                is_exp <= 1'b1;
                                busy_r <= 1'b1;
                                state  <= SQR;
                            end
                            default: begin
`ifdef GF_INV_EN
                                // a^(2^m-2): exponent with every bit but bit 0 set
                                is_exp <= 1'b1;
                                b_r    <= {{(M-1){1'b1}}, 1'b0};
                                busy_r <= 1'b1;
                                state  <= SQR;
`else
                                out_r  <= '0;
                                done_r <= 1'b1;
                                state  <= DONE;
`endif
                            end
                        endcase
                    end
                end
                SQR, MUL: begin
                    prod <= prod_next;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        // Pass complete: commit product and choose the next pass back-to-back
                        prod <= '0;
                        cnt  <= CW'(M-1);
                        acc  <= prod_next;
                        if (state == SQR && b_r[ebit]) begin
                            state <= MUL;
                        end else if (!is_exp || ebit == '0) begin
                            out_r  <= prod_next;
                            done_r <= 1'b1;
                            busy_r <= 1'b0;
                            state  <= DONE;
                        end else begin
                            ebit  <= ebit - 1'b1;
                            state <= SQR;
                        end
                    end
                end
                default: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gf_mul_exp_seq.sv
// tb_gf_mul_exp_seq: directed and random checks of gf_mul_exp_seq against a polynomial-arithmetic model
module tb_gf_mul_exp_seq;
    localparam int W = 8;
    localparam logic [W:0] P = 9'h11B;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_assert = 0;
    int   n_fail = 0;

    gf_mul_exp_seq_if #(.DATA_WIDTH(W)) bus ();

    gf_mul_exp_seq #(.DATA_WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Full carry-less product followed by long division by P
    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] p;
        p = '0;
        for (int i = 0; i < W; i++)
            if (y[i]) p = p ^ ((2*W)'(x) << i);
        for (int i = 2*W-1; i >= W; i--)
            if (p[i]) p = p ^ ((2*W)'(P) << (i - W));
        return p[W-1:0];
    endfunction

    // Exponent as repeated multiplication
    function automatic logic [W-1:0] ref_pow(input logic [W-1:0] x, input int e);
        logic [W-1:0] r;
        r = 1;
        for (int k = 0; k < e; k++) r = ref_mul(r, x);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Issue one op, check latency, busy profile, result, and that starts in DONE are ignored
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] exp_out, input int lat, input int glitch, input string tag);
        int n;
        int busy_bad;
        @(negedge clk);
        bus.op = o;
        bus.a = x;
        bus.b = y;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a = ~x;
        bus.b = ~y;
        bus.op = ~o;
        n = 1;
        busy_bad = 0;
        while (bus.done !== 1'b1 && n < 1000) begin
            if (bus.busy !== 1'b1) busy_bad++;
            bus.start = (n == glitch);
            bus.op = 2'b00;
            @(posedge clk);
            #1;
            n++;
        end
        bus.start = 1'b0;
        check({tag, " latency"}, n, lat);
        check({tag, " busy at done"}, bus.busy, 1'b0);
        check({tag, " busy profile"}, busy_bad, 0);
        check({tag, " out"}, bus.out, exp_out);
        bus.start = 1'b1;
        bus.op = 2'b00;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, " start in done ignored"}, {bus.done, bus.busy}, 2'b00);
        check({tag, " out held"}, bus.out, exp_out);
    endtask

    initial begin
        logic [W-1:0] x, y;
        int done_cnt;
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.a = '0;
        bus.b = '0;
        bus.polyn_red_in = P;
        #1 rst_n = 1'b0;
        #1;
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);
        check("reset out", bus.out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(2'b00, 8'h57, 8'h83, 8'hD4, 1, -1, "add");
        run_op(2'b01, 8'h57, 8'h83, 8'hC1, 9, -1, "mult");
        run_op(2'b10, 8'h02, 8'h08, 8'h1B, 73, -1, "exp 2^8");
        run_op(2'b10, 8'h02, 8'h00, 8'h01, 65, -1, "exp e=0");
        run_op(2'b10, 8'h00, 8'h05, 8'h00, 8*(8+2)+1, -1, "exp a=0");
        run_op(2'b01, 8'h57, 8'h83, 8'hC1, 9, 3, "mult glitch");
        run_op(2'b01, 8'hFF, 8'hFF, ref_mul(8'hFF, 8'hFF), 9, -1, "mult ff");

        for (int i = 0; i < 6; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            run_op(2'b01, x, y, ref_mul(x, y), 9, -1, "rand mult");
            run_op(2'b10, x, y, ref_pow(x, int'(y)), 8*(8+$countones(y))+1, -1, "rand exp");
            run_op(2'b00, x, y, x ^ y, 1, -1, "rand add");
        end

`ifdef GF_INV_EN
        run_op(2'b11, 8'h53, 8'h00, 8'hCA, 121, -1, "inv 53");
        run_op(2'b11, 8'h00, 8'h00, 8'h00, 121, -1, "inv 0");
        x = 8'($urandom_range(1, 255));
        run_op(2'b11, x, 8'h00, ref_pow(x, 254), 121, -1, "rand inv");
        check("rand inv product", ref_mul(x, bus.out), 8'h01);
`else
        run_op(2'b11, 8'h53, 8'h00, 8'h00, 1, -1, "illegal op");
`endif

        @(negedge clk);
        bus.op = 2'b10;
        bus.a = 8'h03;
        bus.b = 8'hFF;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check("busy before abort", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort busy", bus.busy, 1'b0);
        check("abort done", bus.done, 1'b0);
        check("abort out", bus.out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_cnt++;
        end
        check("no done after abort", done_cnt, 0);
        run_op(2'b01, 8'h57, 8'h83, 8'hC1, 9, -1, "mult after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/gf_mul_exp_seq.md
Name: gf_mul_exp_seq

Overview:
- Sequential, parametrised GF(2^m) arithmetic unit; m = DATA_WIDTH.
- Computes add (XOR), modular multiply, and modular exponentiation a^e mod P with a start/busy/done handshake.
- Multiply is bit-serial with interleaved reduction; exponentiation is MSB-first square-and-multiply reusing the same datapath.
- Sits beside the combinational carry-less add/mult/reduce block as its area-optimised, multi-cycle successor for wide fields.

Parameters:
- DATA_WIDTH, 32, field degree m; width of operands, result and exponent.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when busy=0
- op  input  2  00 add, 01 mult, 10 exp, 11 inverse (see Optional Feature)
- polyn_red_in  input  DATA_WIDTH+1  reduction polynomial P; bit DATA_WIDTH must be 1
- a  input  DATA_WIDTH  operand / base
- b  input  DATA_WIDTH  operand (add, mult) or exponent e (exp)
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when out is updated
- out  output  DATA_WIDTH  result; held until the next done

Behaviour:
- Reset (asynchronous, any time, including mid-operation): FSM to IDLE; busy=0, done=0, out=0. Internal accumulator and counters are cleared. No done is produced for an aborted operation.
- IDLE: on start=1 (cycle T), latch op, a, b and polyn_red_in, then go to the op state; busy=1 from T+1. Later input changes have no effect.
- start while busy=1 is ignored and is not queued.
- add: out = a^b. done and new out appear at T+1; busy stays 0 throughout.
- mult: acc=0; for i = m-1 downto 0: acc = (acc<<1) reduced by P, then XOR a if b[i]. One bit per cycle, m cycles. done at T+m+1, and busy drops in the same cycle.
- Reduction step: if acc[m-1] was 1 before the shift, XOR polyn_red_in[m-1:0] into the shifted value. Operands are m bits, so no pre-reduction is needed.
- exp: acc=1; scan e from bit m-1 to 0:
  - Each bit: a SQUARE pass (acc*acc, m cycles).
  - If the bit is 1: an additional MULT pass (acc*a, m cycles).
  - All m exponent bits are scanned, including leading zeros.
  - Latency: done at T + m*(m + popcount(e)) + 1.
- Exp boundaries: e=0 gives out=1. a=0 with e≠0 gives out=0.
- FSM states: IDLE, SQR, MUL, DONE.
  - SQR→MUL when the current exponent bit is 1, otherwise advance to the next bit.
  - The last pass goes to DONE.
  - DONE (one cycle) drives done=1, loads out, clears busy, returns to IDLE.
  - For a plain mult op, the FSM enters MUL directly and then DONE.
- start asserted in the DONE cycle is ignored. The earliest back-to-back start is the cycle after done.
- The bit counter wraps per pass. A new pass starts in the cycle after the previous pass's final bit, with no idle cycles between passes.

Optional Feature:
- Macro GF_INV_EN.
- Defined: op=11 computes a^(2^m-2) (Fermat inverse) as exp with implicit e = 2^m-2, i.e. bits m-1..1 set.
  - Latency: done at T + m*(2m-1) + 1.
  - a=0 gives out=0.
- Undefined: op=11 is illegal. done pulses at T+1 with out=0, and no FSM passes are run.

Test Plan (DATA_WIDTH=8, P=0x11B):
- add: a=0x57, b=0x83 -> out=0xD4, done at T+1, busy never high.
- mult: a=0x57, b=0x83 -> out=0xC1, done at T+9, busy high T+1..T+8.
- exp: a=0x02, e=0x08 -> out=0x1B, done at T+73. Also e=0x00 -> out=0x01 at T+65.
- handshake: start pulsed again at T+3 during a mult -> ignored; single done, result unchanged. After done, a new start is accepted.
- reset: rst_n low at T+20 of an exp -> busy=0, done=0, out=0 immediately; no later done. A new mult after reset is correct.
- GF_INV_EN: a=0x53 -> out=0xCA at T+121. Macro undefined: out=0x00 at T+1.
